// File: rtl/rr_muxnway.sv
// rr_muxnway: N-channel, W-bit valid/ready multiplexer with a registered
// output stage. Selection is either fixed (external sel) or round-robin
// among the valid channels. Each transfer takes one cycle from input
// handshake to out_valid. While out_ready stays high the block sustains
// one word per cycle.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used in mode 0
//   in_data    N*W flattened inputs, channel k at [k*W +: W]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   out_data   registered output word
//   out_chan   channel that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word

// Per-channel request qualification. Each lane decides whether it competes
// for the grant this cycle. In round-robin mode it also reports whether it
// lies above the last-grant pointer, which gives it priority.
module rr_muxnway_lane #(
    parameter int SELW = 2,
    parameter int IDX  = 0
) (
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [SELW-1:0] ptr,
    input  logic            valid,
    output logic            req,
    output logic            req_hi
);
    localparam logic [SELW-1:0] IDX_C = SELW'(IDX);

    always_comb begin
        req    = 1'b0;
        req_hi = 1'b0;
        if (!mode) begin
            // Fixed select: only the addressed lane may request. An
            // out-of-range sel matches no lane, so nothing is granted.
            req    = valid && (sel == IDX_C);
            req_hi = req;
        end else begin
            // Round-robin: lanes above ptr are searched first. ptr itself
            // and the lanes below it form the wrapped second pass.
            req    = valid;
            req_hi = valid && (IDX_C > ptr);
        end
    end
endmodule

module rr_muxnway #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int SELW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);
    generate
        if (N < 2 || SELW != $clog2(N)) begin : g_param_chk
            $error("rr_muxnway: need N >= 2 and SELW == clog2(N)");
        end
    endgenerate

    // Output register and last-grant pointer.
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_chan_q, out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    // Per-lane requests.
    logic [N-1:0]    req;
    logic [N-1:0]    req_hi;

    // Grant decision.
    logic            hi_any, lo_any;
    logic [SELW-1:0] hi_idx, lo_idx;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic            load_en;
    logic            xfer;

    logic [N-1:0][W-1:0] in_data_a;
    assign in_data_a = in_data;

    generate
        for (genvar k = 0; k < N; k++) begin : g_lane
            rr_muxnway_lane #(
                .SELW (SELW),
                .IDX  (k)
            ) u_lane (
                .mode   (mode),
                .sel    (sel),
                .ptr    (ptr_q),
                .valid  (in_valid[k]),
                .req    (req[k]),
                .req_hi (req_hi[k])
            );
        end
    endgenerate

    // Lowest-index pick in each request class. Scanning from the top down
    // leaves the lowest set index in the result. A hit above ptr takes
    // precedence over the wrapped pass. This matches a modulo-N search
    // that starts at ptr+1 and checks ptr last. In mode 0 at most one lane
    // requests, so both classes resolve to the same lane.
    always_comb begin
        hi_any = 1'b0;
        hi_idx = '0;
        lo_any = 1'b0;
        lo_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_hi[k]) begin
                hi_any = 1'b1;
                hi_idx = SELW'(k);
            end
            if (req[k]) begin
                lo_any = 1'b1;
                lo_idx = SELW'(k);
            end
        end
        grant_vld = hi_any || lo_any;
        grant_idx = hi_any ? hi_idx : lo_idx;
    end

    // The register can accept a word when it is empty or being drained this
    // cycle. No ready is offered during reset.
    assign load_en = !out_valid_q || out_ready;
    assign xfer    = load_en && grant_vld && !rst;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (grant_vld) begin
                out_data_d  = in_data_a[grant_idx];
                out_chan_d  = grant_idx;
                out_valid_d = 1'b1;
                ptr_d       = grant_idx;
            end else begin
                // Drain with nothing to refill. The data and channel keep
                // their last values.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;
endmodule
